// File: rtl/bus_dest_bank.sv
// bus_dest_bank
//   Receiving end of the processor data bus. The bus multiplexer drives a
//   17-bit word, and this block captures it into one destination register
//   per clock edge. The destinations are IR, R0..R7 and the ALU operand A.
//   R7 doubles as the program counter.
//
// Optional feature macro: BANK_R0_ZERO_EN
//   When defined, R0 is hard-wired to zero. Writes to R0 are accepted
//   (BANK_done pulses) but discarded, and they never set BANK_err.
//
// Ports
//   Clock            in   system clock, rising edge
//   Resetn           in   asynchronous active-low reset
//   BANK_BUS_in      in   [IR_W-1:0] bus word from the multiplexer
//   BANK_load        in   write strobe
//   BANK_dest        in   [2:0] destination code
//                         001 IR, 010 R[Rx], 011 R[Ry], 100 counter, 101 A;
//                         000, 110 and 111 select no destination
//   BANK_Rx_sel      in   Rx register index
//   BANK_Ry_sel      in   Ry register index
//   BANK_incr        in   counter (R7) increment request
//   BANK_IR_out      out  IR contents
//   BANK_Rx_out      out  R[Rx_sel], combinational read of registered state
//   BANK_Ry_out      out  R[Ry_sel], combinational read of registered state
//   BANK_COUNTER_out out  R7 contents
//   BANK_A_out       out  A contents
//   BANK_done        out  one-cycle pulse in the cycle after an accepted write
//   BANK_err         out  sticky flag; set when a 16-bit destination is
//                         written while bus bit 16 is 1
module bus_dest_bank #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 17,
  parameter int NREG   = 8
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [IR_W-1:0]         BANK_BUS_in,
  input  logic                    BANK_load,
  input  logic [2:0]              BANK_dest,
  input  logic [$clog2(NREG)-1:0] BANK_Rx_sel,
  input  logic [$clog2(NREG)-1:0] BANK_Ry_sel,
  input  logic                    BANK_incr,
  output logic [IR_W-1:0]         BANK_IR_out,
  output logic [DATA_W-1:0]       BANK_Rx_out,
  output logic [DATA_W-1:0]       BANK_Ry_out,
  output logic [DATA_W-1:0]       BANK_COUNTER_out,
  output logic [DATA_W-1:0]       BANK_A_out,
  output logic                    BANK_done,
  output logic                    BANK_err
);

  localparam int IDX_W = $clog2(NREG);
  localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(NREG - 1);

  localparam logic [2:0] DEST_IR  = 3'b001;
  localparam logic [2:0] DEST_RX  = 3'b010;
  localparam logic [2:0] DEST_RY  = 3'b011;
  localparam logic [2:0] DEST_CNT = 3'b100;
  localparam logic [2:0] DEST_A   = 3'b101;

  logic [IR_W-1:0]   ir_q,   ir_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] a_q,    a_d;
  logic              done_q, done_d;
  logic              err_q,  err_d;

  // Decoded write request
  logic              wr_acc;     // any accepted write (drives done)
  logic              reg_wr;     // write into the general register file
  logic [IDX_W-1:0]  reg_idx;    // target register index for reg_wr
  logic              wr16;       // write to any 16-bit destination that is kept
  logic              r0_drop;    // write aimed at hard-wired R0
  logic              bus_hi;
  logic [DATA_W-1:0] bus_lo;

  // Combinational read port; R0 reads as zero when it is hard-wired.
  function automatic logic [DATA_W-1:0] rd_reg(input logic [IDX_W-1:0] idx,
                                               input logic [DATA_W-1:0] val);
`ifdef BANK_R0_ZERO_EN
    rd_reg = (idx == '0) ? '0 : val;
`else
    rd_reg = (idx == '0) ? val : val;
`endif
  endfunction

  always_comb begin
    bus_hi  = BANK_BUS_in[IR_W-1];
    bus_lo  = BANK_BUS_in[DATA_W-1:0];

    wr_acc  = BANK_load && (BANK_dest >= DEST_IR) && (BANK_dest <= DEST_A);
    reg_wr  = BANK_load && ((BANK_dest == DEST_RX) || (BANK_dest == DEST_RY) ||
                            (BANK_dest == DEST_CNT));

    reg_idx = CNT_IDX;
    if (BANK_dest == DEST_RX) reg_idx = BANK_Rx_sel;
    if (BANK_dest == DEST_RY) reg_idx = BANK_Ry_sel;

`ifdef BANK_R0_ZERO_EN
    r0_drop = reg_wr && (reg_idx == '0);
`else
    r0_drop = 1'b0;
`endif

    wr16 = ((reg_wr && !r0_drop) || (BANK_load && BANK_dest == DEST_A));
  end

  always_comb begin
    ir_d   = ir_q;
    a_d    = a_q;
    regs_d = regs_q;
    done_d = wr_acc;
    // Bit 16 is only a problem when it is actually dropped into a kept
    // 16-bit register; discarded R0 writes do not count.
    err_d  = err_q || (wr16 && bus_hi);

    // The increment is applied first so that a write to R7 in the same
    // cycle overrides it.
    if (BANK_incr) regs_d[NREG-1] = regs_q[NREG-1] + DATA_W'(1);

    if (BANK_load && BANK_dest == DEST_IR) ir_d = BANK_BUS_in;
    if (BANK_load && BANK_dest == DEST_A)  a_d  = bus_lo;
    if (reg_wr && !r0_drop)                regs_d[reg_idx] = bus_lo;

`ifdef BANK_R0_ZERO_EN
    regs_d[0] = '0;
`endif
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ir_q   <= '0;
      a_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      ir_q   <= ir_d;
      a_q    <= a_d;
      done_q <= done_d;
      err_q  <= err_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign BANK_IR_out      = ir_q;
  assign BANK_A_out       = a_q;
  assign BANK_COUNTER_out = regs_q[NREG-1];
  assign BANK_done        = done_q;
  assign BANK_err         = err_q;
  assign BANK_Rx_out      = rd_reg(BANK_Rx_sel, regs_q[BANK_Rx_sel]);
  assign BANK_Ry_out      = rd_reg(BANK_Ry_sel, regs_q[BANK_Ry_sel]);

endmodule

// File: tb/tb_bus_dest_bank.sv
module tb_bus_dest_bank;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [16:0] BANK_BUS_in;
  logic        BANK_load;
  logic [2:0]  BANK_dest;
  logic [2:0]  BANK_Rx_sel;
  logic [2:0]  BANK_Ry_sel;
  logic        BANK_incr;
  logic [16:0] BANK_IR_out;
  logic [15:0] BANK_Rx_out;
  logic [15:0] BANK_Ry_out;
  logic [15:0] BANK_COUNTER_out;
  logic [15:0] BANK_A_out;
  logic        BANK_done;
  logic        BANK_err;

  bus_dest_bank dut (
    .Clock(Clock), .Resetn(Resetn), .BANK_BUS_in(BANK_BUS_in),
    .BANK_load(BANK_load), .BANK_dest(BANK_dest), .BANK_Rx_sel(BANK_Rx_sel),
    .BANK_Ry_sel(BANK_Ry_sel), .BANK_incr(BANK_incr), .BANK_IR_out(BANK_IR_out),
    .BANK_Rx_out(BANK_Rx_out), .BANK_Ry_out(BANK_Ry_out),
    .BANK_COUNTER_out(BANK_COUNTER_out), .BANK_A_out(BANK_A_out),
    .BANK_done(BANK_done), .BANK_err(BANK_err)
  );

  always #5 Clock = ~Clock;

  int passed = 0;
  int total  = 0;

`ifdef BANK_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  // Reference model: architectural contents of the bank
  int m_ir, m_a, m_done, m_err;
  int m_r [8];

  function automatic int exp_rd(input int sel);
    if (R0Z && sel == 0) return 0;
    return m_r[sel];
  endfunction

  task automatic model_reset();
    m_ir = 0; m_a = 0; m_done = 0; m_err = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 0;
  endtask

  // What the next rising edge does, stated directly from the rules.
  task automatic model_edge();
    int tgt;
    int lo, hi;
    lo  = int'(BANK_BUS_in) % 65536;
    hi  = int'(BANK_BUS_in) / 65536;
    tgt = -1;
    if (BANK_incr) m_r[7] = (m_r[7] + 1) % 65536;
    m_done = 0;
    if (BANK_load) begin
      case (int'(BANK_dest))
        1: begin m_ir = int'(BANK_BUS_in); m_done = 1; end
        2: begin tgt = int'(BANK_Rx_sel); m_done = 1; end
        3: begin tgt = int'(BANK_Ry_sel); m_done = 1; end
        4: begin tgt = 7; m_done = 1; end
        5: begin m_a = lo; m_done = 1; if (hi == 1) m_err = 1; end
        default: ;
      endcase
    end
    if (tgt >= 0 && !(R0Z && tgt == 0)) begin
      m_r[tgt] = lo;
      if (hi == 1) m_err = 1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, " ir"},   int'(BANK_IR_out),      m_ir);
    chk({tag, " a"},    int'(BANK_A_out),       m_a);
    chk({tag, " cnt"},  int'(BANK_COUNTER_out), m_r[7]);
    chk({tag, " rx"},   int'(BANK_Rx_out),      exp_rd(int'(BANK_Rx_sel)));
    chk({tag, " ry"},   int'(BANK_Ry_out),      exp_rd(int'(BANK_Ry_sel)));
    chk({tag, " done"}, int'(BANK_done),        m_done);
    chk({tag, " err"},  int'(BANK_err),         m_err);
  endtask

  task automatic idle();
    BANK_load = 1'b0; BANK_dest = 3'd0; BANK_incr = 1'b0; BANK_BUS_in = '0;
  endtask

  // Apply current inputs for one clock edge, then check after the edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge Clock);
    #1;
    check_all(tag);
  endtask

  task automatic wr(input logic [2:0] dest, input logic [2:0] sel,
                    input logic [16:0] bus, input string tag);
    BANK_load = 1'b1; BANK_dest = dest; BANK_Rx_sel = sel; BANK_BUS_in = bus;
    step(tag);
    idle();
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      BANK_Rx_sel = 3'(i);
      #1;
      chk($sformatf("%s r%0d", tag, i), int'(BANK_Rx_out), exp_rd(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    Resetn = 1'b0; BANK_Rx_sel = '0; BANK_Ry_sel = '0;
    idle();
    model_reset();
    #12;
    check_all("por");
    Resetn = 1'b1;

    // Preload everything with 0xAAAA, then reset asynchronously.
    wr(3'b001, 3'd0, 17'h0AAAA, "pre_ir");
    wr(3'b101, 3'd0, 17'h0AAAA, "pre_a");
    for (int i = 0; i < 8; i++) wr(3'b010, 3'(i), 17'h0AAAA, "pre_r");
    check_regs("preloaded");
    #2;
    Resetn = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check_regs("async_rst");

    // Reset held across an edge with a write pending discards the write.
    BANK_load = 1'b1; BANK_dest = 3'b001; BANK_BUS_in = 17'h1FFFF;
    @(posedge Clock); #1;
    check_all("rst_mid_wr");
    idle();
    Resetn = 1'b1;
    #1;
    check_all("rst_release");

    // IR takes all 17 bits; done pulses exactly one cycle.
    wr(3'b001, 3'd0, 17'h12345, "ir_wr");
    step("ir_done_clear");

    // Rx write, then an Ry write with bit16 set raises sticky err.
    wr(3'b010, 3'd3, 17'h0BEEF, "r3_wr");
    chk("r3_val", int'(BANK_Rx_out), 16'hBEEF);
    BANK_Ry_sel = 3'd4;
    wr(3'b011, 3'd0, 17'h1BEEF, "r4_err");
    chk("r4_val", int'(BANK_Ry_out), 16'hBEEF);
    chk("err_set", int'(BANK_err), 1);
    step("err_sticky");

    // Counter wrap, increment vs write priority, increment alongside another write.
    wr(3'b100, 3'd0, 17'h0FFFF, "cnt_ffff");
    BANK_incr = 1'b1;
    step("cnt_wrap");
    chk("cnt_zero", int'(BANK_COUNTER_out), 0);
    BANK_load = 1'b1; BANK_dest = 3'b100; BANK_BUS_in = 17'h00040;
    step("cnt_wr_wins");
    chk("cnt_40", int'(BANK_COUNTER_out), 16'h0040);
    BANK_dest = 3'b010; BANK_Rx_sel = 3'd7; BANK_BUS_in = 17'h00123;
    step("cnt_rx7_wins");
    BANK_Rx_sel = 3'd5; BANK_BUS_in = 17'h00555;
    step("incr_and_r5");
    idle();

    // Same-cycle write to R2 is seen on Ry only after the edge.
    wr(3'b010, 3'd2, 17'h00777, "r2_old");
    BANK_Ry_sel = 3'd2;
    BANK_load = 1'b1; BANK_dest = 3'b010; BANK_Rx_sel = 3'd2; BANK_BUS_in = 17'h01111;
    #1;
    chk("ry_old_same_cycle", int'(BANK_Ry_out), 16'h0777);
    step("r2_new");
    chk("ry_new", int'(BANK_Ry_out), 16'h1111);
    idle();
    step("r2_done_clear");

    // Code 110 with load is ignored.
    BANK_load = 1'b1; BANK_dest = 3'b110; BANK_BUS_in = 17'h1ABCD;
    step("code110");
    BANK_dest = 3'b000;
    step("code000");
    idle();

    // R0 behaviour depends on the build option.
    wr(3'b010, 3'd0, 17'h05555, "r0_wr");
    chk("r0_val", int'(BANK_Rx_out), R0Z ? 0 : 16'h5555);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      BANK_load   = ($urandom_range(0, 3) != 0);
      BANK_dest   = 3'($urandom_range(0, 7));
      BANK_Rx_sel = 3'($urandom_range(0, 7));
      BANK_Ry_sel = 3'($urandom_range(0, 7));
      BANK_incr   = ($urandom_range(0, 2) == 0);
      BANK_BUS_in = {($urandom_range(0, 15) == 0), 16'($urandom)};
      if (n == 150) begin
        #2;
        Resetn = 1'b0;
        model_reset();
        #1;
        check_all("rand_rst");
        Resetn = 1'b1;
      end
      step("rand");
    end
    idle();
    step("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
